// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating count of inserted bubbles.
module id_ex_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           ctrl_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    input  logic [4:0]            rd_addr_i,
    input  logic [3:0]            funct_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    output logic [10:0]           ctrl_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [4:0]            rs1_addr_o,
    output logic [4:0]            rs2_addr_o,
    output logic [4:0]            rd_addr_o,
    output logic [3:0]            funct_o,
    output logic                  valid_o,
    output logic                  stall_o,
    output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic hazard;
    logic [CNT_WIDTH-1:0] cnt_next;

    // A load in EX whose destination feeds the instruction in decode.
    // rs2 is compared even for instruction types that never read it.
    assign hazard = valid_o & ctrl_o[5] & (rd_addr_o != 5'd0) &
                    ((rd_addr_o == rs1_addr_i) | (rd_addr_o == rs2_addr_i));

    // Upstream holds PC and IF/ID while stall_o is high; a flush kills the
    // decode instruction anyway, so it never needs a retry.
    assign stall_o = hazard & ~flush_i;

    assign cnt_next = (bubble_cnt_o == CNT_MAX) ? bubble_cnt_o : bubble_cnt_o + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_o       <= '0;
            pc_o         <= '0;
            rs1_data_o   <= '0;
            rs2_data_o   <= '0;
            imm_o        <= '0;
            rs1_addr_o   <= '0;
            rs2_addr_o   <= '0;
            rd_addr_o    <= '0;
            funct_o      <= '0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= '0;
        end else if (flush_i || (!hold_i && hazard)) begin
            ctrl_o       <= '0;
            pc_o         <= '0;
            rs1_data_o   <= '0;
            rs2_data_o   <= '0;
            imm_o        <= '0;
            rs1_addr_o   <= '0;
            rs2_addr_o   <= '0;
            rd_addr_o    <= '0;
            funct_o      <= '0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= cnt_next;
        end else if (!hold_i) begin
            ctrl_o       <= ctrl_i;
            pc_o         <= pc_i;
            rs1_data_o   <= rs1_data_i;
            rs2_data_o   <= rs2_data_i;
            imm_o        <= imm_i;
            rs1_addr_o   <= rs1_addr_i;
            rs2_addr_o   <= rs2_addr_i;
            rd_addr_o    <= rd_addr_i;
            funct_o      <= funct_i;
            valid_o      <= (ctrl_i != 11'd0);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed steps plus random traffic
// compared against a cycle-level reference model of the stage.
module tb_id_ex_pipe;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   ctrl_i;
    logic [DW-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]    rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [3:0]    funct_i;
    logic          flush_i, hold_i;
    logic [10:0]   ctrl_o;
    logic [DW-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]    rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [3:0]    funct_o;
    logic          valid_o, stall_o;
    logic [CW-1:0] bubble_cnt_o;

    typedef struct packed {
        logic [10:0]   ctrl;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs1d;
        logic [DW-1:0] rs2d;
        logic [DW-1:0] imm;
        logic [4:0]    rs1a;
        logic [4:0]    rs2a;
        logic [4:0]    rda;
        logic [3:0]    funct;
        logic          valid;
        logic [CW-1:0] cnt;
    } ex_t;

    localparam int EW = $bits(ex_t);

    ex_t           m;
    int            m_bubbles;
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    id_ex_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .ctrl_i(ctrl_i), .pc_i(pc_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .funct_i(funct_i), .flush_i(flush_i), .hold_i(hold_i),
        .ctrl_o(ctrl_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .imm_o(imm_o), .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .funct_o(funct_o),
        .valid_o(valid_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic ex_t observed();
        ex_t o;
        o = '{ctrl_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o,
              rs2_addr_o, rd_addr_o, funct_o, valid_o, bubble_cnt_o};
        return o;
    endfunction

    // Reference model: a real load in EX blocks any decode reader of its rd.
    function automatic logic model_hazard();
        return m.valid && m.ctrl[5] && (m.rda != 5'd0) &&
               ((m.rda == rs1_addr_i) || (m.rda == rs2_addr_i));
    endfunction

    function automatic ex_t model_bubble();
        ex_t b;
        int  sat;
        b = '0;
        m_bubbles = m_bubbles + 1;
        sat = (m_bubbles > (2**CW - 1)) ? (2**CW - 1) : m_bubbles;
        b.cnt = sat[CW-1:0];
        return b;
    endfunction

    task automatic model_edge();
        ex_t n;
        n = m;
        if (!reset) begin
            n = '0;
            m_bubbles = 0;
        end else if (flush_i) begin
            n = model_bubble();
        end else if (hold_i) begin
            n = m;
        end else if (model_hazard()) begin
            n = model_bubble();
        end else begin
            n = '{ctrl_i, pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i,
                  rs2_addr_i, rd_addr_i, funct_i, (ctrl_i != 11'd0), m.cnt};
        end
        m = n;
        exp_q.push_back(n);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: apply one decode cycle, check stall, clock it, check the stage
    task automatic drive(input logic rst, input logic fl, input logic hd,
                         input logic [10:0] c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd,
                         input logic [DW-1:0] pc);
        logic          exp_stall;
        logic [EW-1:0] e;
        ex_t           o;
        @(negedge clk);
        reset      = rst;
        flush_i    = fl;
        hold_i     = hd;
        ctrl_i     = c;
        rs1_addr_i = r1;
        rs2_addr_i = r2;
        rd_addr_i  = rd;
        pc_i       = pc;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        imm_i      = $urandom;
        funct_i    = 4'($urandom_range(0, 15));
        #1;
        exp_stall = model_hazard() && !flush_i;
        chk("stall_o", {63'd0, stall_o}, {63'd0, exp_stall});
        model_edge();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = observed();
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL stage observed=%h expected=%h", o, e);
        end
    endtask

    initial begin
        m = '0;
        m_bubbles = 0;
        reset = 1'b0; flush_i = 1'b1; hold_i = 1'b1;
        ctrl_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0; funct_i = '0;

        // reset overrides flush/hold with live inputs
        drive(1'b0, 1'b1, 1'b1, 11'h0E8, 5'd3, 5'd4, 5'd3, 32'h1234);
        drive(1'b0, 1'b0, 1'b0, 11'h040, 5'd1, 5'd2, 5'd3, 32'h5678);
        chk("reset_valid", {63'd0, valid_o}, 64'd0);
        chk("reset_cnt", {48'd0, bubble_cnt_o}, 64'd0);

        // R-type load
        drive(1'b1, 1'b0, 1'b0, 11'h040, 5'd1, 5'd2, 5'd3, 32'h0040_0010);
        chk("rtype_ctrl", {53'd0, ctrl_o}, 64'h040);
        chk("rtype_pc", {32'd0, pc_o}, 64'h0040_0010);
        chk("rtype_valid", {63'd0, valid_o}, 64'd1);

        // load-use on rs1: one bubble, then the retried instruction loads
        drive(1'b1, 1'b0, 1'b0, 11'h0E8, 5'd2, 5'd0, 5'd5, 32'h14);
        drive(1'b1, 1'b0, 1'b0, 11'h040, 5'd5, 5'd6, 5'd7, 32'h18);
        chk("lu_valid", {63'd0, valid_o}, 64'd0);
        chk("lu_cnt", {48'd0, bubble_cnt_o}, 64'd1);
        drive(1'b1, 1'b0, 1'b0, 11'h040, 5'd5, 5'd6, 5'd7, 32'h18);
        chk("lu_retry_valid", {63'd0, valid_o}, 64'd1);

        // 0x0D9 then a reader of its rd
        drive(1'b1, 1'b0, 1'b0, 11'h0D9, 5'd1, 5'd2, 5'd5, 32'h1C);
        drive(1'b1, 1'b0, 1'b0, 11'h040, 5'd5, 5'd2, 5'd8, 32'h20);

        // load to x0 never stalls
        drive(1'b1, 1'b0, 1'b0, 11'h0E8, 5'd1, 5'd0, 5'd0, 32'h24);
        drive(1'b1, 1'b0, 1'b0, 11'h040, 5'd0, 5'd0, 5'd9, 32'h28);
        chk("x0_cnt", {48'd0, bubble_cnt_o}, 64'd1);

        // hold three cycles with changing inputs, then flush under hold
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 1'b1, 11'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), $urandom);
        drive(1'b1, 1'b1, 1'b1, 11'h040, 5'd1, 5'd2, 5'd3, 32'h30);
        chk("hold_flush_cnt", {48'd0, bubble_cnt_o}, 64'd2);

        // load-use on rs2 with a flush in the same cycle
        drive(1'b1, 1'b0, 1'b0, 11'h0E8, 5'd1, 5'd2, 5'd7, 32'h34);
        drive(1'b1, 1'b1, 1'b0, 11'h040, 5'd3, 5'd7, 5'd4, 32'h38);
        chk("hz_flush_cnt", {48'd0, bubble_cnt_o}, 64'd3);
        drive(1'b1, 1'b0, 1'b0, 11'h040, 5'd3, 5'd7, 5'd4, 32'h3C);

        // random traffic on a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [10:0] c;
            c = 11'($urandom);
            if ($urandom_range(0, 2) == 0) c[5] = 1'b1;
            if ($urandom_range(0, 9) == 0) c = '0;
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 6) == 0), c,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom);
        end

        // drive the bubble counter to saturation with flushes
        drive(1'b0, 1'b0, 1'b0, 11'h0, 5'd0, 5'd0, 5'd0, 32'h0);
        while (m_bubbles < 2**CW - 1)
            drive(1'b1, 1'b1, 1'b0, 11'h040, 5'd1, 5'd2, 5'd3, $urandom);
        chk("sat_reach", {48'd0, bubble_cnt_o}, 64'hFFFF);
        drive(1'b1, 1'b1, 1'b0, 11'h040, 5'd1, 5'd2, 5'd3, 32'h40);
        drive(1'b1, 1'b0, 1'b0, 11'h0E8, 5'd1, 5'd2, 5'd6, 32'h44);
        drive(1'b1, 1'b0, 1'b0, 11'h040, 5'd6, 5'd2, 5'd3, 32'h48);
        chk("sat_hold", {48'd0, bubble_cnt_o}, 64'hFFFF);

        // reset in the middle of a stall, then a normal load
        drive(1'b1, 1'b0, 1'b0, 11'h0E8, 5'd1, 5'd2, 5'd6, 32'h4C);
        drive(1'b0, 1'b0, 1'b0, 11'h040, 5'd6, 5'd2, 5'd3, 32'h50);
        chk("post_reset_cnt", {48'd0, bubble_cnt_o}, 64'd0);
        chk("post_reset_ctrl", {53'd0, ctrl_o}, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 11'h040, 5'd6, 5'd2, 5'd3, 32'h50);
        chk("first_load_pc", {32'd0, pc_o}, 64'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
